puzzle_loader: RTL and testbench
================================

Name: puzzle_loader

Overview:
- Writer-side counterpart to the game checker, which only reads the sudoku RAM.
- On a start pulse, writes one of four built-in 4x4 puzzles into the sudoku RAM (4 rows x 24 bits) with write-protect bits set on given cells.
- Optionally applies a digit relabel so the same puzzle looks different between games.
- Drives a RAM port (typically port b, muxed while busy), and signals busy/done to the interface controller.

Parameters:
- GIVEN_MASK, 16'h9669: bit r*4+c = 1 means cell (r,c) is a given; 0 means the cell is blank.
- SHUFFLE, 1: 1 enables the digit relabel; 0 forces rot=0.
- RD_LAT, 2: cycles from address issue to compare of ramQ (used only under the macro).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- start  in  1  one-cycle load request
- puzzleSel  in  2  puzzle index, sampled with start
- ramQ  in  24  RAM read data (used only under the macro)
- ramAddr  out  2  RAM row address
- ramData  out  24  RAM write data
- ramWren  out  1  RAM write enable
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- verifyErr  out  1  readback mismatch, sticky (0 without the macro)

Behaviour:
- Registered outputs:
  - All outputs are registered; reset value of every output is 0.
  - The rot counter and the FSM reset to 0 / IDLE.
- Cell format:
  - Row word bits [6c+5:6c] hold cell c.
  - [5] = protect, [4] = 0, [3:0] = value.
  - Given cell: protect=1, value=relabel(S[r][c]).
  - Blank cell: all 6 bits 0.
- Base solution S (puzzle 0), rows: 1234 / 3412 / 2143 / 4321.
  - puzzle 1 = transpose of S.
  - puzzle 2 = S rows in order 2,3,0,1.
  - puzzle 3 = transpose of puzzle 2.
- Relabel: v -> ((v-1+rot) mod 4)+1 for v in 1..4.
- rot source:
  - 2-bit free-running counter, resets to 0, increments on every CLK edge.
  - rot is latched from this counter at the edge that accepts start.
- FSM states: IDLE, WRITE, VERIFY (macro only), FINISH.
- IDLE: start=1 at edge E0 latches puzzleSel and rot, enters WRITE.
  - Outputs at E0: busy=1, ramWren=1, ramAddr=0, ramData=row0.
- WRITE: at E1..E3, ramAddr 1..3 with matching rows, ramWren stays 1.
  - At E4 without the macro: ramWren=0, ramAddr=0, ramData=0, busy=0, done=1 (FINISH).
  - At E4 with the macro: go to VERIFY.
- FINISH: done pulses for exactly one cycle, then IDLE.
- Start-to-done latency: 4 cycles (no macro).
- start while busy: ignored, no queueing.
- start in the same cycle done is high: ignored; start is accepted only in IDLE.
- RST asserted mid-load: outputs clear to 0 immediately (asynchronous), FSM returns to IDLE.
  - The partially written RAM is left as is; no cleanup.
- ramWren is never high outside WRITE.

Optional Feature:
- Macro: PUZZLE_LOADER_VERIFY_EN.
- Defined:
  - After E3 the FSM enters VERIFY and issues read addresses 0..3 on consecutive cycles with ramWren=0.
  - ramQ is compared against the expected row RD_LAT cycles after each issue.
  - Any mismatch sets verifyErr; verifyErr holds until the next accepted start clears it.
  - done pulses the cycle after the last compare; busy drops with done.
  - Latency: 4 + 4 + RD_LAT cycles.
- Undefined:
  - No VERIFY state; ramQ is ignored; verifyErr is tied to 0.

Test Plan:
- SHUFFLE=0, puzzleSel=0, start pulse -> four writes at addr 0..3.
  - row0 = cells {1,2,3,4} with protect per mask nibble 9, i.e. cells 0 and 3 given, cells 1 and 2 zero.
  - done occurs exactly 4 cycles after start; busy is high for those 4 cycles.
- SHUFFLE=1, start accepted on the 6th edge after reset release (rot=5 mod 4=1), puzzleSel=0 -> given values relabelled 1->2, 2->3, 3->4, 4->1.
  - Blank cells remain 6'h00.
- puzzleSel=1,2,3 with SHUFFLE=0 -> written rows match transpose, band swap and transposed band swap of S.
  - Every written value is in 1..4.
- start re-pulsed during WRITE, and RST asserted at E2 -> the extra start is ignored.
  - On RST, all outputs are 0 the same cycle; no further writes; a later start restarts the load from addr 0.
- Macro defined, RAM model with one row corrupted -> verifyErr=1 at done and stays set until the next start.
  - A clean RAM gives verifyErr=0, with done after 8+RD_LAT cycles.

Source files
------------

// File: rtl/puzzle_loader.sv
// Loads one of four built-in 4x4 sudoku puzzles into the 4-row RAM on a start pulse.
// Define PUZZLE_LOADER_VERIFY_EN to add a readback check of the written rows.
module puzzle_loader #(
   parameter logic [15:0] GIVEN_MASK = 16'h9669,
   parameter bit          SHUFFLE    = 1'b1,
   parameter int          RD_LAT     = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [1:0]  puzzleSel,
   input  logic [23:0] ramQ,
   output logic [1:0]  ramAddr,
   output logic [23:0] ramData,
   output logic        ramWren,
   output logic        busy,
   output logic        done,
   output logic        verifyErr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WRITE  = 2'd1,
`ifdef PUZZLE_LOADER_VERIFY_EN
      ST_VERIFY = 2'd2,
`endif
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [7:0] LAT8 = 8'(RD_LAT);

   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [1:0]  rot_q;
   logic [1:0]  sel_q;
   logic [1:0]  addr_q;
   logic [23:0] data_q;
   logic        wren_q;
   logic        busy_q;
   logic        done_q;
   logic [1:0]  rot_d;
   logic [1:0]  addr_d;

   // Solution rows stored as (digit-1) codes, 2 bits per cell, cell 0 in the top bits.
   function automatic logic [1:0] base_code(input logic [1:0] r, input logic [1:0] c);
      logic [7:0] row;
      case (r)
         2'd0:    row = 8'h1B;
         2'd1:    row = 8'hB1;
         2'd2:    row = 8'h4E;
         default: row = 8'hE4;
      endcase
      case (c)
         2'd0:    base_code = row[7:6];
         2'd1:    base_code = row[5:4];
         2'd2:    base_code = row[3:2];
         default: base_code = row[1:0];
      endcase
   endfunction

   function automatic logic [1:0] puzzle_code(input logic [1:0] sel, input logic [1:0] r,
                                              input logic [1:0] c);
      case (sel)
         2'd0:    puzzle_code = base_code(r, c);
         2'd1:    puzzle_code = base_code(c, r);
         2'd2:    puzzle_code = base_code(r ^ 2'd2, c);
         default: puzzle_code = base_code(c ^ 2'd2, r);
      endcase
   endfunction

   // Relabel is a rotation of the digit code, so the mod-4 wrap comes free from 2-bit add.
   function automatic logic [23:0] row_word(input logic [1:0] sel, input logic [1:0] rot,
                                            input logic [1:0] r);
      logic [23:0] w;
      logic [1:0]  code;
      logic [3:0]  val;
      w = 24'd0;
      for (int c = 0; c < 4; c++) begin
         code = puzzle_code(sel, r, 2'(c));
         val  = {2'b00, code + rot} + 4'd1;
         if (GIVEN_MASK[{r, 2'(c)}]) begin
            w[6*c +: 6] = {2'b10, val};
         end
      end
      return w;
   endfunction

   always_comb begin
      rot_d  = SHUFFLE ? cnt_q : 2'd0;
      addr_d = addr_q + 2'd1;
   end

`ifdef PUZZLE_LOADER_VERIFY_EN
   localparam logic [7:0] VEND = LAT8 + 8'd4;
   logic [7:0] vcnt_q;
   logic       verr_q;
   logic [7:0] vnext_d;
   logic [7:0] vcmp_d;

   always_comb begin
      vnext_d = vcnt_q + 8'd1;
      vcmp_d  = vnext_d - LAT8;
   end

   assign verifyErr = verr_q;
`else
   logic unused_s;
   assign unused_s  = ^{ramQ, LAT8};
   assign verifyErr = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
         rot_q   <= 2'd0;
         sel_q   <= 2'd0;
         addr_q  <= 2'd0;
         data_q  <= 24'd0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PUZZLE_LOADER_VERIFY_EN
         vcnt_q  <= 8'd0;
         verr_q  <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_q + 2'd1;
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_WRITE;
                  sel_q   <= puzzleSel;
                  rot_q   <= rot_d;
                  addr_q  <= 2'd0;
                  data_q  <= row_word(puzzleSel, rot_d, 2'd0);
                  wren_q  <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef PUZZLE_LOADER_VERIFY_EN
                  verr_q  <= 1'b0;
`endif
               end
            end
            ST_WRITE: begin
               if (addr_q != 2'd3) begin
                  addr_q <= addr_d;
                  data_q <= row_word(sel_q, rot_q, addr_d);
               end else begin
                  wren_q <= 1'b0;
                  addr_q <= 2'd0;
                  data_q <= 24'd0;
`ifdef PUZZLE_LOADER_VERIFY_EN
                  state_q <= ST_VERIFY;
                  vcnt_q  <= 8'd0;
`else
                  state_q <= ST_FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end
            end
`ifdef PUZZLE_LOADER_VERIFY_EN
            // vcnt_q counts edges since read address 0 was issued.
            ST_VERIFY: begin
               vcnt_q <= vnext_d;
               addr_q <= (vnext_d < 8'd4) ? vnext_d[1:0] : 2'd0;
               if ((vnext_d >= LAT8) && (vcmp_d <= 8'd3) &&
                   (ramQ != row_word(sel_q, rot_q, vcmp_d[1:0]))) begin
                  verr_q <= 1'b1;
               end
               if (vnext_d == VEND) begin
                  state_q <= ST_FINISH;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
`endif
            ST_FINISH: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               wren_q  <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ramAddr = addr_q;
   assign ramData = data_q;
   assign ramWren = wren_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_puzzle_loader.sv
// Bench for puzzle_loader: two instances (SHUFFLE=1 and SHUFFLE=0) under shared random stimulus,
// checked each cycle against a grid-level model of the load schedule and puzzle contents.
module tb_puzzle_loader;
   localparam int          RD_LAT = 2;
   localparam logic [15:0] MASK   = 16'h9669;
`ifdef PUZZLE_LOADER_VERIFY_EN
   localparam int DONE_K = 8 + RD_LAT;
   localparam bit VERIFY = 1'b1;
`else
   localparam int DONE_K = 4;
   localparam bit VERIFY = 1'b0;
`endif

   logic        CLK       = 1'b0;
   logic        RST       = 1'b0;
   logic        start     = 1'b0;
   logic [1:0]  puzzleSel = 2'd0;
   logic [23:0] q_w    [2];
   logic [1:0]  addr_w [2];
   logic [23:0] data_w [2];
   logic        wren_w [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic        verr_w [2];
   logic [23:0] ram_m  [2][4];

   int   total = 0;
   int   bad   = 0;
   logic corrupt_en  = 1'b0;
   logic [1:0] corrupt_row = 2'd2;

   int   m_k     = -1;
   int   m_edges = 0;
   int   m_sel   = 0;
   int   m_rot   = 0;
   logic m_verr  = 1'b0;

   always #5 CLK = ~CLK;

   puzzle_loader #(.GIVEN_MASK(MASK), .SHUFFLE(1'b1), .RD_LAT(RD_LAT)) u_shuf (
      .CLK(CLK), .RST(RST), .start(start), .puzzleSel(puzzleSel), .ramQ(q_w[0]),
      .ramAddr(addr_w[0]), .ramData(data_w[0]), .ramWren(wren_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .verifyErr(verr_w[0]));

   puzzle_loader #(.GIVEN_MASK(MASK), .SHUFFLE(1'b0), .RD_LAT(RD_LAT)) u_plain (
      .CLK(CLK), .RST(RST), .start(start), .puzzleSel(puzzleSel), .ramQ(q_w[1]),
      .ramAddr(addr_w[1]), .ramData(data_w[1]), .ramWren(wren_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .verifyErr(verr_w[1]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   function automatic logic [23:0] model_row(input int sel, input int rot, input int r);
      int s  [4][4];
      int p2 [4][4];
      int g  [4][4];
      int ord [4];
      int v;
      logic [23:0] w;
      s[0] = '{1, 2, 3, 4};
      s[1] = '{3, 4, 1, 2};
      s[2] = '{2, 1, 4, 3};
      s[3] = '{4, 3, 2, 1};
      ord  = '{2, 3, 0, 1};
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            p2[i][j] = s[ord[i]][j];
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            case (sel)
               0:       g[i][j] = s[i][j];
               1:       g[i][j] = s[j][i];
               2:       g[i][j] = p2[i][j];
               default: g[i][j] = p2[j][i];
            endcase
      w = 24'd0;
      for (int c = 0; c < 4; c++) begin
         if (MASK[r*4 + c]) begin
            v = ((g[r][c] - 1 + rot) % 4) + 1;
            w[6*c +: 6] = {2'b10, 4'(v)};
         end
      end
      return w;
   endfunction

   // Schedule model: m_k is the number of edges since the accepting edge, -1 when idle.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_k     <= -1;
         m_edges <= 0;
         m_verr  <= 1'b0;
      end else begin
         m_edges <= m_edges + 1;
         if (m_k < 0) begin
            if (start) begin
               m_k    <= 0;
               m_sel  <= int'(puzzleSel);
               m_rot  <= m_edges % 4;
               m_verr <= 1'b0;
            end
         end else if (m_k >= DONE_K) begin
            m_k <= -1;
         end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == DONE_K) m_verr <= corrupt_en;
         end
      end
   end

   // RAM with one read register stage, so data for an address is seen RD_LAT edges after issue.
   always @(posedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         if (wren_w[d]) ram_m[d][addr_w[d]] <= data_w[d];
         q_w[d] <= ram_m[d][addr_w[d]] ^
                   ((corrupt_en && addr_w[d] == corrupt_row) ? 24'h000001 : 24'h000000);
      end
   end

   always @(negedge CLK) begin : cmp
      bit          wr;
      bit          by;
      logic [1:0]  ea;
      logic [23:0] ed;
      wr = (m_k >= 0 && m_k < 4);
      by = (m_k >= 0 && m_k < DONE_K);
      ea = wr ? 2'(m_k) : ((VERIFY && m_k >= 4 && m_k < 8) ? 2'(m_k - 4) : 2'd0);
      for (int d = 0; d < 2; d++) begin
         ed = wr ? model_row(m_sel, (d == 0) ? m_rot : 0, m_k) : 24'd0;
         chk($sformatf("busy[%0d]", d), 32'(busy_w[d]), 32'(by));
         chk($sformatf("done[%0d]", d), 32'(done_w[d]), 32'(m_k == DONE_K));
         chk($sformatf("wren[%0d]", d), 32'(wren_w[d]), 32'(wr));
         chk($sformatf("addr[%0d]", d), 32'(addr_w[d]), 32'(ea));
         chk($sformatf("data[%0d]", d), 32'(data_w[d]), 32'(ed));
         if (!(m_k >= 4 + RD_LAT && m_k < DONE_K))
            chk($sformatf("verifyErr[%0d]", d), 32'(verr_w[d]), 32'(VERIFY ? m_verr : 1'b0));
      end
   end

   initial begin
      #1 RST = 1'b1;
      repeat (3) step();
      RST = 1'b0;
      chk("pin_p0_r0_rot0", model_row(0, 0, 0), 24'h900021);
      chk("pin_p0_r0_rot1", model_row(0, 1, 0), 24'h840022);
      chk("pin_p0_r1_rot0", model_row(0, 0, 1), 24'h021900);
      chk("pin_p2_r0_rot0", model_row(2, 0, 0), 24'h8C0022);

      // Accept on the 6th edge after release: rot = 5 mod 4 = 1.
      repeat (5) step();
      start = 1'b1; puzzleSel = 2'd0; step(); start = 1'b0;
      chk("e0_shuf_row0", 32'(data_w[0]), 32'h840022);
      chk("e0_plain_row0", 32'(data_w[1]), 32'h900021);
      chk("e0_busy", 32'(busy_w[0]), 32'd1);
      start = 1'b1; puzzleSel = 2'd3; step(); start = 1'b0;
      chk("e1_addr", 32'(addr_w[1]), 32'd1);
      chk("e1_plain_row1", 32'(data_w[1]), 32'h021900);
      step();
      RST = 1'b1;
      #1;
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_wren", 32'(wren_w[1]), 32'd0);
      chk("rst_data", 32'(data_w[0]), 32'd0);
      step(); RST = 1'b0;
      repeat (3) step();

      for (int s = 1; s < 4; s++) begin
         start = 1'b1; puzzleSel = 2'(s); step(); start = 1'b0;
         chk("restart_addr0", 32'(addr_w[1]), 32'd0);
         repeat (DONE_K - 1) step();
         chk("done_before_latency", 32'(done_w[1]), 32'd0);
         step();
         chk("done_at_latency", 32'(done_w[1]), 32'd1);
         start = 1'b1; step(); start = 1'b0;
         chk("start_on_done_ignored", 32'(busy_w[1]), 32'd0);
         step();
      end

`ifdef PUZZLE_LOADER_VERIFY_EN
      corrupt_en = 1'b1;
      start = 1'b1; puzzleSel = 2'd1; step(); start = 1'b0;
      repeat (DONE_K) step();
      chk("verr_corrupt", 32'(verr_w[0]), 32'd1);
      corrupt_en = 1'b0;
      repeat (4) step();
      chk("verr_sticky", 32'(verr_w[0]), 32'd1);
      start = 1'b1; step(); start = 1'b0;
      chk("verr_cleared", 32'(verr_w[0]), 32'd0);
      repeat (DONE_K + 2) step();
      chk("verr_clean", 32'(verr_w[0]), 32'd0);
`endif

      repeat (600) begin
         start     = ($urandom_range(0, 2) == 0);
         puzzleSel = 2'($urandom_range(0, 3));
         RST       = ($urandom_range(0, 79) == 0);
         step();
      end
      RST = 1'b0; start = 1'b0;
      repeat (DONE_K + 3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
